// File: rtl/mem_loader_ram_pkg.sv
// Shared definitions for the Mock8080 program memory and its byte-stream loader.
// Holds the loader state encoding and the default memory geometry.
package mem_loader_ram_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 8;

   // Encoding is visible on the ld_state debug port, so keep the values fixed.
   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LEN  = 2'd1,
      LD_DATA = 2'd2,
      LD_DONE = 2'd3
   } ld_state_t;

endpackage

// File: rtl/mem_loader_ram_ram_1rw.sv
// Single-write-port RAM with one registered read port.
// A read of the address written in the same cycle returns the old contents.
module ram_1rw #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Storage is deliberately left out of reset so loaded code survives it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_loader_ram.sv
// Mock8080 program/data memory with a framed byte-stream loader (ADDR, LEN, data).
// The loader holds the CPU in reset and owns the RAM write port until run_req.
module mem_loader_ram
   import mem_loader_ram_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk_qzt,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              run_req,
   output logic              cpu_hold,
   output logic              cpu_reset,
   output logic [ADDR_W-1:0] cpu_res_addr,
   output logic [1:0]        ld_state
);

   localparam int CNT_W = ADDR_W + 1;

   // Loader handshake: a byte moves on any rising edge where ld_valid & ld_ready;
   // ld_ready drops only in DONE, and ld_data need not be held once accepted.
   ld_state_t         state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [ADDR_W-1:0] base, base_n;
   logic [ADDR_W-1:0] res_addr_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              hold_n;
   logic              creset_n;
   logic              xfer;
   logic              ld_we;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   assign ld_ready = (state != LD_DONE);
   assign xfer     = ld_valid & ld_ready;
   assign ld_state = state;

   always_ff @(posedge clk_qzt) begin
      if (reset) begin
         state        <= LD_IDLE;
         ptr          <= '0;
         base         <= '0;
         cnt          <= '0;
         cpu_hold     <= 1'b0;
         cpu_reset    <= 1'b0;
         cpu_res_addr <= '0;
      end else begin
         state        <= state_n;
         ptr          <= ptr_n;
         base         <= base_n;
         cnt          <= cnt_n;
         cpu_hold     <= hold_n;
         cpu_reset    <= creset_n;
         cpu_res_addr <= res_addr_n;
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      base_n     = base;
      cnt_n      = cnt;
      hold_n     = cpu_hold;
      creset_n   = cpu_reset;
      res_addr_n = cpu_res_addr;
      ld_we      = 1'b0;

      case (state)
         LD_IDLE: begin
            if (xfer) begin
               ptr_n    = ADDR_W'(ld_data);
               base_n   = ADDR_W'(ld_data);
               hold_n   = 1'b1;
               creset_n = 1'b1;
               state_n  = LD_LEN;
            end
         end
         LD_LEN: begin
            if (xfer) begin
               // A zero length byte stands for a full-memory frame.
               if (ld_data == '0) begin
                  cnt_n = {1'b1, {ADDR_W{1'b0}}};
               end else begin
                  cnt_n = CNT_W'(ld_data);
               end
               state_n = LD_DATA;
            end
         end
         LD_DATA: begin
            if (xfer) begin
               ld_we = 1'b1;
               ptr_n = ptr + ADDR_W'(1);
               cnt_n = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  // The CPU fetches from res_addr+1 after reset, so point one below base.
                  res_addr_n = base - ADDR_W'(1);
                  state_n    = LD_DONE;
               end
            end
         end
         LD_DONE: begin
            // cpu_reset stays static here; the CPU only samples it on its step edges.
            if (run_req) begin
               creset_n = 1'b0;
               hold_n   = 1'b0;
               state_n  = LD_IDLE;
            end
         end
         default: begin
            state_n = LD_IDLE;
         end
      endcase
   end

   // While the CPU is held the loader owns the write port; CPU writes are dropped.
   assign ram_we    = !reset && (cpu_hold ? ld_we : cpu_we);
   assign ram_waddr = cpu_hold ? ptr : cpu_addr;
   assign ram_wdata = cpu_hold ? ld_data : cpu_wdata;

   ram_1rw #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk_qzt),
      .reset (reset),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (cpu_addr),
      .rdata (cpu_rdata)
   );

endmodule

// File: tb/tb_mem_loader_ram.sv
// Directed bench for mem_loader_ram: CPU bus access, framed loads, wrap,
// full-length frames, write-port arbitration and reset mid-load.
module tb_mem_loader_ram;

   logic       clk_qzt = 1'b0;
   logic       reset;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_we;
   logic [7:0] cpu_rdata;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       run_req;
   logic       cpu_hold;
   logic       cpu_reset;
   logic [7:0] cpu_res_addr;
   logic [1:0] ld_state;

   int checks = 0;
   int errors = 0;

   mem_loader_ram #(
      .ADDR_W (8),
      .DATA_W (8)
   ) dut (
      .clk_qzt      (clk_qzt),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_we       (cpu_we),
      .cpu_rdata    (cpu_rdata),
      .ld_valid     (ld_valid),
      .ld_data      (ld_data),
      .ld_ready     (ld_ready),
      .run_req      (run_req),
      .cpu_hold     (cpu_hold),
      .cpu_reset    (cpu_reset),
      .cpu_res_addr (cpu_res_addr),
      .ld_state     (ld_state)
   );

   always #5 clk_qzt = ~clk_qzt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_qzt);
      #1;
   endtask

   // Offers one loader byte and waits (bounded) for it to be accepted.
   task automatic send_byte(input logic [7:0] b);
      int n;
      ld_valid = 1'b1;
      ld_data  = b;
      n = 0;
      while (!ld_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) check("send_timeout", 32'(ld_ready), 32'd1);
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic read_mem(input logic [7:0] a, output logic [7:0] d);
      cpu_addr = a;
      cpu_we   = 1'b0;
      tick();
      d = cpu_rdata;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_we    = 1'b1;
      tick();
      cpu_we    = 1'b0;
   endtask

   task automatic pulse_run();
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
   endtask

   initial begin
      logic [7:0] rd;

      reset     = 1'b1;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_we    = 1'b0;
      ld_valid  = 1'b0;
      ld_data   = '0;
      run_req   = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_state", 32'(ld_state), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
      check("rst_res_addr", 32'(cpu_res_addr), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      check("rst_rdata", 32'(cpu_rdata), 32'd0);

      // 1. CPU write/read, plus read-old-data on a same-address write
      cpu_write(8'h40, 8'hBB);
      cpu_addr  = 8'h40;
      cpu_wdata = 8'hAA;
      cpu_we    = 1'b1;
      tick();
      cpu_we = 1'b0;
      check("rd_during_wr_old", 32'(cpu_rdata), 32'hBB);
      read_mem(8'h40, rd);
      check("cpu_rw_40", 32'(rd), 32'hAA);

      // 2. Basic load
      send_byte(8'h10);
      check("ld_hold_set", 32'(cpu_hold), 32'd1);
      check("ld_cpu_reset_set", 32'(cpu_reset), 32'd1);
      check("ld_state_len", 32'(ld_state), 32'd1);
      send_byte(8'h03);
      check("ld_state_data", 32'(ld_state), 32'd2);
      send_byte(8'h06);
      send_byte(8'h05);
      send_byte(8'h00);
      check("basic_state_done", 32'(ld_state), 32'd3);
      check("basic_res_addr", 32'(cpu_res_addr), 32'h0F);
      check("basic_cpu_reset", 32'(cpu_reset), 32'd1);
      check("basic_ld_ready", 32'(ld_ready), 32'd0);
      ld_valid = 1'b1;
      ld_data  = 8'h77;
      tick();
      tick();
      ld_valid = 1'b0;
      check("done_backpressure", 32'(ld_state), 32'd3);
      read_mem(8'h10, rd);
      check("basic_mem10", 32'(rd), 32'h06);
      read_mem(8'h11, rd);
      check("basic_mem11", 32'(rd), 32'h05);
      read_mem(8'h12, rd);
      check("basic_mem12", 32'(rd), 32'h00);
      read_mem(8'h13, rd);
      check("basic_no_extra_write", 32'(rd) == 32'h77 ? 32'd1 : 32'd0, 32'd0);
      pulse_run();
      check("run_cpu_reset", 32'(cpu_reset), 32'd0);
      check("run_hold", 32'(cpu_hold), 32'd0);
      check("run_state_idle", 32'(ld_state), 32'd0);

      // 3. Address wrap
      send_byte(8'hFE);
      send_byte(8'h03);
      send_byte(8'hA1);
      send_byte(8'hA2);
      send_byte(8'hA3);
      check("wrap_state_done", 32'(ld_state), 32'd3);
      check("wrap_res_addr", 32'(cpu_res_addr), 32'hFD);
      read_mem(8'hFE, rd);
      check("wrap_memFE", 32'(rd), 32'hA1);
      read_mem(8'hFF, rd);
      check("wrap_memFF", 32'(rd), 32'hA2);
      read_mem(8'h00, rd);
      check("wrap_mem00", 32'(rd), 32'hA3);
      pulse_run();
      check("wrap_released", 32'(ld_state), 32'd0);

      // 4. LEN=0 means 256 bytes
      send_byte(8'h00);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i));
         if (i == 254) check("len0_not_done_255", 32'(ld_state), 32'd2);
      end
      check("len0_done_256", 32'(ld_state), 32'd3);
      check("len0_res_addr", 32'(cpu_res_addr), 32'hFF);
      for (int i = 0; i < 256; i++) begin
         read_mem(8'(i), rd);
         check($sformatf("len0_mem%02h", i), 32'(rd), 32'(i));
      end
      pulse_run();
      check("len0_released", 32'(ld_state), 32'd0);

      // 5. Hold arbitration and run_req ignored outside DONE
      cpu_write(8'h20, 8'h33);
      send_byte(8'h50);
      send_byte(8'h02);
      send_byte(8'h99);
      cpu_addr  = 8'h20;
      cpu_wdata = 8'h55;
      cpu_we    = 1'b1;
      run_req   = 1'b1;
      tick();
      cpu_we  = 1'b0;
      run_req = 1'b0;
      check("arb_run_ignored_state", 32'(ld_state), 32'd2);
      check("arb_run_ignored_hold", 32'(cpu_hold), 32'd1);
      send_byte(8'h98);
      check("arb_state_done", 32'(ld_state), 32'd3);
      read_mem(8'h20, rd);
      check("arb_mem20_kept", 32'(rd), 32'h33);
      read_mem(8'h50, rd);
      check("arb_mem50", 32'(rd), 32'h99);
      read_mem(8'h51, rd);
      check("arb_mem51", 32'(rd), 32'h98);
      pulse_run();

      // 6. Reset mid-load
      send_byte(8'h30);
      send_byte(8'h05);
      send_byte(8'h11);
      send_byte(8'h22);
      check("mid_state_data", 32'(ld_state), 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_state", 32'(ld_state), 32'd0);
      check("mid_rst_hold", 32'(cpu_hold), 32'd0);
      check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd0);
      check("mid_rst_res_addr", 32'(cpu_res_addr), 32'd0);
      check("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
      read_mem(8'h30, rd);
      check("mid_mem30", 32'(rd), 32'h11);
      read_mem(8'h31, rd);
      check("mid_mem31", 32'(rd), 32'h22);
      read_mem(8'h32, rd);
      check("mid_mem32_old", 32'(rd), 32'h32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
